// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the FIFO write port between two valid/ready
// producers. Grants alternate round-robin, and each grant is capped at
// MAX_BURST words. FIFO-full stalls hold the grant without releasing it.
// A wrapping transfer counter is kept for each requester.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  input  logic              fifo_full,
  output logic              wr_enable_fifo,
  output logic [DATA_W-1:0] wr_data,
  output logic              grant_active,
  output logic              grant_id,
  output logic [CNT_W-1:0]  xfer_cnt0,
  output logic [CNT_W-1:0]  xfer_cnt1
);

  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [BURST_W-1:0]  burst_cnt_r;
  logic                last_grant_r;
  logic [CNT_W-1:0]    xfer_cnt0_r;
  logic [CNT_W-1:0]    xfer_cnt1_r;
  logic                req0_ready_s;
  logic                req1_ready_s;
  logic                xfer_s;
  logic                release_s;
  logic [DATA_W-1:0]   wr_data_s;

  // Next-state selection, holder handshake and FIFO write path.
  always_comb begin
    next_state_s = state_r;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    xfer_s       = 1'b0;
    release_s    = 1'b0;
    wr_data_s    = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        // Arbitration takes one cycle. On a tie, the requester that did not hold the last grant wins.
        if (req0_valid && req1_valid) begin
          next_state_s = last_grant_r ? GRANT0 : GRANT1;
        end else if (req0_valid) begin
          next_state_s = GRANT0;
        end else if (req1_valid) begin
          next_state_s = GRANT1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT0: begin
        req0_ready_s = !fifo_full;
        xfer_s       = req0_valid && !fifo_full;
        if (xfer_s) begin
          wr_data_s = req0_data;
        end else begin
          wr_data_s = {DATA_W{1'b0}};
        end
        // A full stall with valid held never releases. An idle holder does release.
        release_s = (xfer_s && (req0_last || (burst_cnt_r == BURST_LAST))) || !req0_valid;
        if (release_s) begin
          next_state_s = req1_valid ? GRANT1 : IDLE;
        end else begin
          next_state_s = GRANT0;
        end
      end
      GRANT1: begin
        req1_ready_s = !fifo_full;
        xfer_s       = req1_valid && !fifo_full;
        if (xfer_s) begin
          wr_data_s = req1_data;
        end else begin
          wr_data_s = {DATA_W{1'b0}};
        end
        release_s = (xfer_s && (req1_last || (burst_cnt_r == BURST_LAST))) || !req1_valid;
        if (release_s) begin
          next_state_s = req0_valid ? GRANT0 : IDLE;
        end else begin
          next_state_s = GRANT1;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Grant state, round-robin history and per-grant burst length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      burst_cnt_r  <= BURST_W'(0);
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        burst_cnt_r <= BURST_W'(0);
        if (next_state_s == GRANT0) begin
          last_grant_r <= 1'b0;
        end else if (next_state_s == GRANT1) begin
          last_grant_r <= 1'b1;
        end else begin
          last_grant_r <= last_grant_r;
        end
      end else if (xfer_s) begin
        burst_cnt_r <= burst_cnt_r + BURST_W'(1);
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end
  end

  // Wrapping per-requester counts of words written to the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt0_r <= CNT_W'(0);
      xfer_cnt1_r <= CNT_W'(0);
    end else if (xfer_s && (state_r == GRANT0)) begin
      xfer_cnt0_r <= xfer_cnt0_r + CNT_W'(1);
    end else if (xfer_s && (state_r == GRANT1)) begin
      xfer_cnt1_r <= xfer_cnt1_r + CNT_W'(1);
    end else begin
      xfer_cnt0_r <= xfer_cnt0_r;
      xfer_cnt1_r <= xfer_cnt1_r;
    end
  end

  assign req0_ready     = req0_ready_s;
  assign req1_ready     = req1_ready_s;
  assign wr_enable_fifo = xfer_s;
  assign wr_data        = wr_data_s;
  assign grant_active   = (state_r != IDLE);
  assign grant_id       = (state_r == GRANT1);
  assign xfer_cnt0      = xfer_cnt0_r;
  assign xfer_cnt1      = xfer_cnt1_r;

endmodule
